redmule_mx_enc_arbiter: RTL

Round-robin arbiter and sequencer that shares one `redmule_mx_encoder` instance between `NUM_REQ` FP16 producers. A block is a fixed burst of `NUM_GROUPS` lane-group beats.

- Grants are locked per block: once a requester wins, it owns the encoder until its encoded MX block and shared exponent have been handed back.
- Sits between the producers (e.g. Z-row streamers) and the encoder's FP16 input and MX value/exponent outputs.

---
 rtl/redmule_pkg.sv | 16 +
 rtl/redmule_rr_picker.sv | 35 +++
 rtl/redmule_mx_enc_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE MX encoder arbiter.
//   redmule_mx_arb_state_e : arbiter FSM state encoding (IDLE / FEED / DRAIN)
//   MX_ELEM_W              : width of one MX-encoded element in bits
//   MX_EXP_W               : width of the E8M0 shared exponent in bits
package redmule_pkg;

    localparam int MX_ELEM_W = 8;
    localparam int MX_EXP_W  = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_FEED  = 2'd1,
        ARB_DRAIN = 2'd2
    } redmule_mx_arb_state_e;

endpackage

// File: rtl/redmule_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit,
// searching cyclically upward from a start pointer.
// Ports:
//   i_req   [NUM_REQ]          request vector
//   i_ptr   [$clog2(NUM_REQ)]  start index of the search (highest priority)
//   o_valid                    at least one request is set
//   o_idx   [$clog2(NUM_REQ)]  index of the winner (don't-care if !o_valid)
module redmule_rr_picker #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic                       o_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_idx
);

    // Rotate so that bit 0 of w_rot corresponds to requester i_ptr.
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;

    assign w_dbl   = {i_req, i_req} >> i_ptr;
    assign w_rot   = w_dbl[NUM_REQ-1:0];
    assign o_valid = |i_req;

    // Walk from the far end down so the lowest rotated offset wins.
    always_comb begin
        o_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_idx = $clog2(NUM_REQ)'((int'(i_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/redmule_mx_enc_arbiter.sv
// Round-robin arbiter/sequencer sharing one redmule_mx_encoder between
// NUM_REQ FP16 producers. A grant is held for a whole block: NUM_GROUPS
// input beats are fed to the encoder, then the encoded MX values and the
// shared exponent are handed back to the same requester before the next
// arbitration. All handshakes are combinational pass-through (no storage).
// Optional feature macro: REDMULE_MX_ARB_STATS_EN adds blk_cnt_o, a set of
// per-requester 16-bit saturating completed-block counters.
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   req_valid_i/ready_o/data_i       per-requester FP16 beat stream
//   enc_fp16_valid_o/ready_i/data_o  to encoder FP16 input
//   enc_val_*/enc_exp_*              from encoder MX value / exponent outputs
//   rsp_valid_o/ready_i              per-requester encoded-block handshake
//   rsp_val_data_o, rsp_exp_data_o   shared response data buses
//   owner_o                          current / last owner
//   busy_o                           FSM not in IDLE
//   blk_cnt_o                        completed blocks per requester (stats only)
module redmule_mx_enc_arbiter
    import redmule_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_W    = 256,
    parameter int BITW      = 16,
    parameter int NUM_LANES = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_ni,
    input  logic [NUM_REQ-1:0]                         req_valid_i,
    output logic [NUM_REQ-1:0]                         req_ready_o,
    input  logic [NUM_REQ-1:0][NUM_LANES*BITW-1:0]     req_data_i,
    output logic                                       enc_fp16_valid_o,
    input  logic                                       enc_fp16_ready_i,
    output logic [NUM_LANES*BITW-1:0]                  enc_fp16_data_o,
    input  logic                                       enc_val_valid_i,
    output logic                                       enc_val_ready_o,
    input  logic [DATA_W-1:0]                          enc_val_data_i,
    input  logic                                       enc_exp_valid_i,
    output logic                                       enc_exp_ready_o,
    input  logic [MX_EXP_W-1:0]                        enc_exp_data_i,
    output logic [NUM_REQ-1:0]                         rsp_valid_o,
    input  logic [NUM_REQ-1:0]                         rsp_ready_i,
    output logic [DATA_W-1:0]                          rsp_val_data_o,
    output logic [MX_EXP_W-1:0]                        rsp_exp_data_o,
    output logic [$clog2(NUM_REQ)-1:0]                 owner_o,
    output logic                                       busy_o
`ifdef REDMULE_MX_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]                   blk_cnt_o
`endif
);

    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int NUM_GROUPS = DATA_W / MX_ELEM_W / NUM_LANES;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);
    localparam logic [IDX_W-1:0] LAST_REQ = IDX_W'(NUM_REQ - 1);

    redmule_mx_arb_state_e r_state, w_state_nxt;
    logic [IDX_W-1:0]      r_owner, w_owner_nxt;
    logic [IDX_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic [GRP_W-1:0]      r_grp_cnt, w_grp_cnt_nxt;
    logic                  w_pick_vld;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_enc_both;
    logic                  w_rsp_hs;

    redmule_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req   (req_valid_i),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ARB_IDLE;
            r_owner   <= '0;
            r_rr_ptr  <= '0;
            r_grp_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_grp_cnt <= w_grp_cnt_nxt;
        end
    end

    // Values and exponent are released together; the block is only
    // complete once both encoder outputs are present.
    assign w_enc_both = enc_val_valid_i & enc_exp_valid_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_grp_cnt_nxt    = r_grp_cnt;
        req_ready_o      = '0;
        enc_fp16_valid_o = 1'b0;
        enc_val_ready_o  = 1'b0;
        enc_exp_ready_o  = 1'b0;
        rsp_valid_o      = '0;
        w_rsp_hs         = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // Arbitration cycle: no data moves.
                if (w_pick_vld) begin
                    w_owner_nxt   = w_pick_idx;
                    w_rr_ptr_nxt  = (w_pick_idx == LAST_REQ) ? '0 : w_pick_idx + 1'b1;
                    w_grp_cnt_nxt = '0;
                    w_state_nxt   = ARB_FEED;
                end
            end
            ARB_FEED: begin
                // Grant is held even if the owner stalls mid-block.
                enc_fp16_valid_o     = req_valid_i[r_owner];
                req_ready_o[r_owner] = enc_fp16_ready_i;
                if (req_valid_i[r_owner] && enc_fp16_ready_i) begin
                    if (r_grp_cnt == LAST_GRP) begin
                        w_grp_cnt_nxt = '0;
                        w_state_nxt   = ARB_DRAIN;
                    end else begin
                        w_grp_cnt_nxt = r_grp_cnt + 1'b1;
                    end
                end
            end
            ARB_DRAIN: begin
                rsp_valid_o[r_owner] = w_enc_both;
                w_rsp_hs             = rsp_ready_i[r_owner] & w_enc_both;
                enc_val_ready_o      = w_rsp_hs;
                enc_exp_ready_o      = w_rsp_hs;
                if (w_rsp_hs) begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Data buses always follow the owner mux / encoder so they never float.
    assign enc_fp16_data_o = req_data_i[r_owner];
    assign rsp_val_data_o  = enc_val_data_i;
    assign rsp_exp_data_o  = enc_exp_data_i;
    assign owner_o         = r_owner;
    assign busy_o          = (r_state != ARB_IDLE);

`ifdef REDMULE_MX_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] r_blk_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_blk_cnt <= '0;
        end else if (w_rsp_hs && (r_blk_cnt[r_owner] != 16'hFFFF)) begin
            r_blk_cnt[r_owner] <= r_blk_cnt[r_owner] + 16'd1;
        end
    end

    assign blk_cnt_o = r_blk_cnt;
`endif

endmodule
